// File: rtl/vga_pkg.sv
// Shared timing constants, phase type and pin-control bundle for the VGA display controller.
package vga_pkg;

  localparam int H_SYNC = 192;
  localparam int H_BP   = 96;
  localparam int H_DISP = 1280;
  localparam int H_FP   = 32;
  localparam int H_DIV  = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 29;
  localparam int V_DISP = 480;
  localparam int V_FP   = 10;
  localparam int V_DIV  = 5;

  localparam int PIX_W = 7;

  // RGB332 field positions inside a framebuffer byte
  localparam int RED_MSB   = 7;
  localparam int RED_LSB   = 5;
  localparam int GREEN_MSB = 4;
  localparam int GREEN_LSB = 2;
  localparam int BLUE_MSB  = 1;
  localparam int BLUE_LSB  = 0;

  typedef enum logic [1:0] {SYNC, BACK, DISP, FRONT} vga_phase_t;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic active;
    logic vblank;
    logic frame_start;
  } pin_ctl_t;

  localparam pin_ctl_t PIN_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0,
                                    vblank: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: position counter, SYNC/BACK/DISP/FRONT phase decode and logical-pixel divider.
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int SYNC_LEN = 192,
  parameter int BP_LEN   = 96,
  parameter int DISP_LEN = 1280,
  parameter int FP_LEN   = 32,
  parameter int DIV      = 10,
  parameter int CNT_W    = 11,
  parameter int DIV_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output vga_phase_t       phase,
  output logic [PIX_W-1:0] pix,
  output logic             wrap,
  output logic [CNT_W-1:0] cnt
);

  localparam int TOTAL = SYNC_LEN + BP_LEN + DISP_LEN + FP_LEN;
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] DISP_START  = CNT_W'(SYNC_LEN + BP_LEN);
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(SYNC_LEN + BP_LEN + DISP_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [PIX_W-1:0] PIX_MAX     = {PIX_W{1'b1}};

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] cnt_next;
  logic [DIV_W-1:0] div_next;
  logic [PIX_W-1:0] pix_next;
  logic             next_in_disp;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      div <= '0;
      pix <= '0;
    end else begin
      cnt <= cnt_next;
      div <= div_next;
      pix <= pix_next;
    end
  end

  always_comb begin
    cnt_next     = cnt;
    div_next     = div;
    pix_next     = pix;
    next_in_disp = 1'b0;
    if (enable) begin
      cnt_next     = wrap ? '0 : cnt + CNT_W'(1);
      next_in_disp = (cnt_next >= DISP_START) && (cnt_next < FRONT_START);
      // Pixel index restarts on DISP entry and saturates once the row is exhausted
      if (!next_in_disp || (phase != DISP)) begin
        div_next = '0;
        pix_next = '0;
      end else if (div == DIV_LAST) begin
        div_next = '0;
        if (pix != PIX_MAX) pix_next = pix + PIX_W'(1);
      end else begin
        div_next = div + DIV_W'(1);
      end
    end
  end

  // Phase is a pure decode of the counter, so it can never disagree with it
  always_comb begin
    phase = FRONT;
    if (cnt < BACK_START)       phase = SYNC;
    else if (cnt < DISP_START)  phase = BACK;
    else if (cnt < FRONT_START) phase = DISP;
    wrap = enable && (cnt == CNT_LAST);
  end

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA display timing controller: H/V sequencing, framebuffer address fetch and a two-stage pin pipeline.
module vga_display_ctrl #(
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int H_DISP = vga_pkg::H_DISP,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_DIV  = vga_pkg::H_DIV,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP,
  parameter int V_DISP = vga_pkg::V_DISP,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_DIV  = vga_pkg::V_DIV
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [2:0]  VGA_RED,
  output logic [2:0]  VGA_GREEN,
  output logic [1:0]  VGA_BLUE,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic        vblank,
  output logic        frame_start
);

  import vga_pkg::*;

  vga_phase_t       h_phase;
  vga_phase_t       v_phase;
  logic [PIX_W-1:0] h_pix;
  logic [PIX_W-1:0] v_pix;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic [10:0]      hcnt;
  logic [9:0]       vcnt;

  pin_ctl_t   ctl_now;
  pin_ctl_t   ctl_d1;
  pin_ctl_t   ctl_d2;
  logic [7:0] rgb_q;

  vga_axis_timer #(
    .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .DISP_LEN(H_DISP), .FP_LEN(H_FP),
    .DIV(H_DIV), .CNT_W(11), .DIV_W(4)
  ) u_h_timer (
    .clk(clk), .reset(reset), .enable(1'b1),
    .phase(h_phase), .pix(h_pix), .wrap(h_wrap), .cnt(hcnt)
  );

  vga_axis_timer #(
    .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .DISP_LEN(V_DISP), .FP_LEN(V_FP),
    .DIV(V_DIV), .CNT_W(10), .DIV_W(3)
  ) u_v_timer (
    .clk(clk), .reset(reset), .enable(h_wrap),
    .phase(v_phase), .pix(v_pix), .wrap(v_wrap_unused), .cnt(vcnt)
  );

  // Pixel registers update on the counter edge, so this address is stage 1 of the pipeline
  assign mem_addr = {v_pix, h_pix};

  always_comb begin
    ctl_now             = PIN_IDLE;
    ctl_now.hsync_n     = (h_phase != SYNC);
    ctl_now.vsync_n     = (v_phase != SYNC);
    ctl_now.active      = (h_phase == DISP) && (v_phase == DISP);
    ctl_now.vblank      = (v_phase != DISP);
    ctl_now.frame_start = (hcnt == 11'd0) && (vcnt == 10'd0);
  end

  // Control bits ride two registers so they land with the colour captured from RAM
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_d1 <= PIN_IDLE;
      ctl_d2 <= PIN_IDLE;
      rgb_q  <= '0;
    end else begin
      ctl_d1 <= ctl_now;
      ctl_d2 <= ctl_d1;
      rgb_q  <= ctl_d1.active ? mem_rdata : 8'h00;
    end
  end

  assign VGA_RED     = rgb_q[RED_MSB:RED_LSB];
  assign VGA_GREEN   = rgb_q[GREEN_MSB:GREEN_LSB];
  assign VGA_BLUE    = rgb_q[BLUE_MSB:BLUE_LSB];
  assign VGA_HSYNC   = ctl_d2.hsync_n;
  assign VGA_VSYNC   = ctl_d2.vsync_n;
  assign vblank      = ctl_d2.vblank;
  assign frame_start = ctl_d2.frame_start;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Bench for vga_display_ctrl: full-size instance over the first lines plus a shrunken instance over whole frames.
module tb_vga_display_ctrl;

  typedef struct {
    int hs, hb, hd, hf, hdiv, vs, vb, vd, vf, vdiv;
  } tim_t;

  typedef struct packed {
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        fs;
    logic [13:0] addr;
  } obs_t;

  typedef struct {
    int          t;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        fs;
    logic [13:0] addr;
  } vec_t;

  localparam obs_t OBS_RESET = {3'b0, 3'b0, 2'b0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd0};
  localparam int   N_BIG     = 58000;
  localparam int   NV        = 17;
  localparam int   FT_S      = 150 * 13;

  tim_t big_p   = '{192, 96, 1280, 32, 10, 2, 29, 480, 10, 5};
  tim_t small_p = '{4, 3, 140, 3, 1, 2, 2, 8, 1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // full-size instance
  logic        reset_b;
  logic [13:0] addr_b;
  logic [7:0]  rdata_b;
  logic [2:0]  r_b, g_b;
  logic [1:0]  bl_b;
  logic        hs_b, vs_b, vb_b, fs_b;

  // shrunken instance
  logic        reset_s;
  logic [13:0] addr_s;
  logic [7:0]  rdata_s;
  logic [2:0]  r_s, g_s;
  logic [1:0]  bl_s;
  logic        hs_s, vs_s, vb_s, fs_s;

  int n_tests = 0;
  int n_fail  = 0;
  bit big_done = 1'b0;
  bit small_done = 1'b0;

  vga_display_ctrl u_dut (
    .clk(clk), .reset(reset_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .VGA_RED(r_b), .VGA_GREEN(g_b), .VGA_BLUE(bl_b),
    .VGA_HSYNC(hs_b), .VGA_VSYNC(vs_b), .vblank(vb_b), .frame_start(fs_b)
  );

  vga_display_ctrl #(
    .H_SYNC(4), .H_BP(3), .H_DISP(140), .H_FP(3), .H_DIV(1),
    .V_SYNC(2), .V_BP(2), .V_DISP(8), .V_FP(1), .V_DIV(3)
  ) u_small (
    .clk(clk), .reset(reset_s), .mem_addr(addr_s), .mem_rdata(rdata_s),
    .VGA_RED(r_s), .VGA_GREEN(g_s), .VGA_BLUE(bl_s),
    .VGA_HSYNC(hs_s), .VGA_VSYNC(vs_s), .vblank(vb_s), .frame_start(fs_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (cycle index -> expected pins) ----------------
  function automatic logic [13:0] addr_at(input int s, input tim_t p);
    int ht, vt, h, v, hx, vx, hp, vp;
    logic [6:0] hp7, vp7;
    ht = p.hs + p.hb + p.hd + p.hf;
    vt = p.vs + p.vb + p.vd + p.vf;
    h  = s % ht;
    v  = (s / ht) % vt;
    hx = h - p.hs - p.hb;
    vx = v - p.vs - p.vb;
    hp = (hx >= 0 && hx < p.hd) ? hx / p.hdiv : 0;
    vp = (vx >= 0 && vx < p.vd) ? vx / p.vdiv : 0;
    if (hp > 127) hp = 127;
    if (vp > 127) vp = 127;
    hp7 = hp[6:0];
    vp7 = vp[6:0];
    return {vp7, hp7};
  endfunction

  function automatic logic [7:0] ram_val(input logic [13:0] a, input int mode, input logic [7:0] salt);
    return (mode != 0) ? 8'hFF : (a[7:0] ^ salt);
  endfunction

  function automatic obs_t expect_at(input int t, input tim_t p, input int mode, input logic [7:0] salt);
    obs_t e;
    int s, ht, vt, h, v;
    logic hdisp, vdisp;
    logic [7:0] d;
    e = OBS_RESET;
    e.addr = addr_at(t, p);
    if (t >= 2) begin
      s  = t - 2;
      ht = p.hs + p.hb + p.hd + p.hf;
      vt = p.vs + p.vb + p.vd + p.vf;
      h  = s % ht;
      v  = (s / ht) % vt;
      hdisp = (h >= p.hs + p.hb) && (h < p.hs + p.hb + p.hd);
      vdisp = (v >= p.vs + p.vb) && (v < p.vs + p.vb + p.vd);
      e.hs = (h >= p.hs);
      e.vs = (v >= p.vs);
      e.vb = !vdisp;
      e.fs = (h == 0) && (v == 0);
      if (hdisp && vdisp) begin
        d   = ram_val(addr_at(s, p), mode, salt);
        e.r = d[7:5];
        e.g = d[4:2];
        e.b = d[1:0];
      end
    end
    return e;
  endfunction

  function automatic obs_t obs_big();
    obs_t o;
    o = {r_b, g_b, bl_b, hs_b, vs_b, vb_b, fs_b, addr_b};
    return o;
  endfunction

  function automatic obs_t obs_small();
    obs_t o;
    o = {r_s, g_s, bl_s, hs_s, vs_s, vb_s, fs_s, addr_s};
    return o;
  endfunction

  // ---------------- full-size instance: reset, first line, first display rows ----------------
  initial begin : big_proc
    vec_t vecs[NV];
    obs_t o, e;
    logic [13:0] prev_addr;
    logic [7:0]  salt_b;
    int vi, hs_low, vs_low, col_l31, first_col, col_l30;
    vecs[0]  = '{0,     1'b1, 1'b1, 1'b1, 1'b0, 14'd0};
    vecs[1]  = '{1,     1'b1, 1'b1, 1'b1, 1'b0, 14'd0};
    vecs[2]  = '{2,     1'b0, 1'b0, 1'b1, 1'b1, 14'd0};
    vecs[3]  = '{3,     1'b0, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[4]  = '{193,   1'b0, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[5]  = '{194,   1'b1, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[6]  = '{1602,  1'b0, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[7]  = '{3201,  1'b1, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[8]  = '{3202,  1'b0, 1'b1, 1'b1, 1'b0, 14'd0};
    vecs[9]  = '{49601, 1'b1, 1'b1, 1'b1, 1'b0, 14'd0};
    vecs[10] = '{49602, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[11] = '{49888, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[12] = '{49898, 1'b1, 1'b1, 1'b0, 1'b0, 14'd1};
    vecs[13] = '{51167, 1'b1, 1'b1, 1'b0, 1'b0, 14'd127};
    vecs[14] = '{51168, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0};
    vecs[15] = '{57888, 1'b1, 1'b1, 1'b0, 1'b0, 14'd128};
    vecs[16] = '{57903, 1'b1, 1'b1, 1'b0, 1'b0, 14'd129};
    vi = 0; hs_low = 0; vs_low = 0; col_l31 = 0; first_col = -1; col_l30 = 0;
    prev_addr = '0;
    salt_b  = 8'($urandom_range(128, 255));
    reset_b = 1'b1;
    rdata_b = 8'hFF;
    for (int t = -2; t <= N_BIG; t++) begin
      @(posedge clk);
      #1;
      o = obs_big();
      if (t < 0) begin
        check($sformatf("big_reset_c%0d", t + 2), o, OBS_RESET);
      end else begin
        e = expect_at(t, big_p, 0, salt_b);
        check($sformatf("big_t%0d", t), o, e);
        if (vi < NV && vecs[vi].t == t) begin
          check($sformatf("big_vec%0d_t%0d", vi, t), {o.hs, o.vs, o.vb, o.fs, o.addr},
                {vecs[vi].hs, vecs[vi].vs, vecs[vi].vb, vecs[vi].fs, vecs[vi].addr});
          vi++;
        end
        if (t >= 2 && t < 1602) hs_low += int'(!o.hs);
        if (t >= 2) vs_low += int'(!o.vs);
        if (t >= 2 + 30 * 1600 && t < 2 + 31 * 1600 && {o.r, o.g, o.b} != 8'h00) col_l30++;
        if (t >= 2 + 31 * 1600 && t < 2 + 32 * 1600 && {o.r, o.g, o.b} != 8'h00) begin
          if (first_col < 0) first_col = t - (2 + 31 * 1600);
          col_l31++;
        end
        rdata_b   = ram_val(prev_addr, 0, salt_b);
        prev_addr = addr_b;
      end
      if (t == 0) reset_b = 1'b0;
    end
    check("big_hsync_low_cycles", hs_low, 192);
    check("big_vsync_low_cycles", vs_low, 3200);
    check("big_line30_colour_cycles", col_l30, 0);
    check("big_line31_colour_cycles", col_l31, 1280);
    check("big_line31_colour_start", first_col, 288);
    check("big_vectors_applied", vi, NV);
    big_done = 1'b1;
  end

  // ---------------- shrunken instance: whole frames and mid-frame resets ----------------
  int          t_s;
  int          mode_s;
  logic [7:0]  salt_s;
  logic [13:0] prev_s;
  int          last_fs, first_fs_t, vb_cnt, vs_cnt, hs_cnt, col_cnt;

  task automatic small_reset(input int n, input int new_mode);
    reset_s = 1'b1;
    rdata_s = 8'hFF;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("small_reset_c%0d", i), obs_small(), OBS_RESET);
    end
    reset_s    = 1'b0;
    t_s        = 0;
    mode_s     = new_mode;
    salt_s     = 8'($urandom_range(0, 255));
    prev_s     = '0;
    last_fs    = -1;
    first_fs_t = -1;
    vb_cnt = 0; vs_cnt = 0; hs_cnt = 0; col_cnt = 0;
  endtask

  task automatic small_run(input int n);
    obs_t o, e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t_s++;
      o = obs_small();
      e = expect_at(t_s, small_p, mode_s, salt_s);
      check($sformatf("small_t%0d", t_s), o, e);
      if (o.fs) begin
        if (first_fs_t < 0) first_fs_t = t_s;
        if (last_fs >= 0) begin
          check("small_frame_period", t_s - last_fs, FT_S);
          check("small_vblank_cycles", vb_cnt, 5 * 150);
          check("small_vsync_low_cycles", vs_cnt, 2 * 150);
          check("small_hsync_low_cycles", hs_cnt, 4 * 13);
          if (mode_s != 0) check("small_active_ff_cycles", col_cnt, 140 * 8);
        end
        last_fs = t_s;
        vb_cnt = 0; vs_cnt = 0; hs_cnt = 0; col_cnt = 0;
      end
      if (last_fs >= 0) begin
        vb_cnt  += int'(o.vb);
        vs_cnt  += int'(!o.vs);
        hs_cnt  += int'(!o.hs);
        col_cnt += int'({o.r, o.g, o.b} == 8'hFF);
      end
      rdata_s = ram_val(prev_s, mode_s, salt_s);
      prev_s  = addr_s;
    end
  endtask

  initial begin : small_proc
    reset_s = 1'b1;
    rdata_s = 8'hFF;
    small_reset(3, 0);
    small_run(2 * FT_S + 10);
    check("small_first_fs_after_reset", first_fs_t, 2);
    for (int k = 0; k < 2; k++) begin
      small_run($urandom_range(50, FT_S - 50));
      small_reset($urandom_range(1, 4), (k == 0) ? 1 : 0);
      small_run(2 * FT_S + 10);
      check($sformatf("small_first_fs_after_midreset%0d", k), first_fs_t, 2);
    end
    small_done = 1'b1;
  end

  initial begin : finish_proc
    wait (big_done && small_done);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
